// File: rtl/sm_result_bcd.sv
// Result stream consumer: buffers signed results in a FIFO, converts each one
// to sign + BCD magnitude with a serial double-dabble engine and hands it to the
// display stage over valid/ready. Reports end of program once all results are out.
module sm_result_bcd #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  input  logic [DATA_W-1:0]     out_data,
  input  logic                  fin,
  input  logic                  bcd_ready,
  output logic                  bcd_valid,
  output logic                  bcd_neg,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic [ADDR_W:0]       fifo_count,
  output logic                  overflow,
  output logic                  all_done
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W);

  localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [CntW-1:0] LastIter  = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // FIFO state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              fin_seen_q, fin_seen_d;

  // Converter state
  state_e            state_q, state_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   iter_q, iter_d;

  logic              push, pop, drop;
  logic [DATA_W-1:0] head;
  logic [BcdW-1:0]   bcd_adj;

  assign head = mem_q[rd_ptr_q];

  // FIFO control: a pop frees a slot on the same edge, so a push into a full FIFO
  // is accepted whenever the converter pops on that edge.
  always_comb begin
    pop        = (state_q == StIdle) && (count_q != '0);
    push       = d_valid && ((count_q != CountFull) || pop);
    drop       = d_valid && (count_q == CountFull) && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    fin_seen_d = fin_seen_q | fin;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

  // Double-dabble correction: add 3 to every digit >= 5 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter next-state: pop/capture in idle, DATA_W shift steps, then hold for handshake
  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          neg_d   = head[DATA_W-1];
          // Two's complement negation maps the most negative value onto itself,
          // which reads back correctly as an unsigned magnitude.
          mag_d   = head[DATA_W-1] ? -head : head;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        bcd_d  = {bcd_adj[BcdW-2:0], mag_q[DATA_W-1]};
        mag_d  = {mag_q[DATA_W-2:0], 1'b0};
        iter_d = iter_q + CntW'(1);
        if (iter_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bcd_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards buffered and in-flight results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      fin_seen_q <= 1'b0;
      state_q    <= StIdle;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      fin_seen_q <= fin_seen_d;
      state_q    <= state_d;
      neg_q      <= neg_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
    end
  end

  // Outputs: result fields are forced to zero unless a result is on offer
  always_comb begin
    bcd_valid  = (state_q == StDone);
    bcd_neg    = bcd_valid & neg_q;
    bcd_digits = bcd_valid ? bcd_q : '0;
    fifo_count = count_q;
    overflow   = overflow_q;
    all_done   = fin_seen_q && (count_q == '0) && (state_q == StIdle);
  end

endmodule
